music_sequencer: RTL and testbench

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

---
 rtl/music_pkg.sv | 23 ++
 rtl/tick_gen.sv | 35 +++
 rtl/music_sequencer.sv | 160 ++++++++++++++++
 tb/tb_music_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer: FSM state encoding and stream byte codes.
// Optional build macro: MUSIC_SEQ_LOOP_EN (looping playback, consumed by music_sequencer).
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_NOTE = 3'd1,
        ST_WAIT_NOTE  = 3'd2,
        ST_FETCH_DUR  = 3'd3,
        ST_WAIT_DUR   = 3'd4,
        ST_PLAY       = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam logic [7:0] END_OF_SONG = 8'h00;
    localparam int         REST_BIT    = 7;

    // A duration byte of zero encodes the longest note, 256 ticks.
    function automatic logic [8:0] decode_duration(input logic [7:0] dur_byte);
        return (dur_byte == 8'h00) ? 9'd256 : {1'b0, dur_byte};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Tempo tick generator: while enabled, emits a one-clock tick every TICK_DIV clocks.
// Dropping enable returns the count to zero so every enable period starts a fresh tick.
module tick_gen #(
    parameter int TICK_DIV = 12000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Music sequencer: fetches note/duration byte pairs from a latency-DEC_LAT stream decoder
// and plays them on a tempo tick. Define MUSIC_SEQ_LOOP_EN to loop the song forever.
module music_sequencer
    import music_pkg::*;
#(
    parameter int TICK_DIV = 12000,
    parameter int DEC_LAT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] value,
    output logic       read,
    output logic       restart,
    output logic [6:0] note,
    output logic       gate,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] WAIT_LAST = 4'(DEC_LAT - 1);

    state_t     state_q,   state_d;
    logic [3:0] wait_q,    wait_d;
    logic       rest_q,    rest_d;
    logic [6:0] note_q,    note_d;
    logic [8:0] dur_q,     dur_d;
    logic [8:0] beat_q,    beat_d;
    logic       restart_q, restart_d;

    logic play_en;
    logic tick;
    logic last_beat;

    assign play_en   = (state_q == ST_PLAY);
    assign last_beat = (beat_q == dur_q - 9'd1);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (play_en),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        rest_d    = rest_q;
        note_d    = note_q;
        dur_d     = dur_q;
        beat_d    = beat_q;
        restart_d = 1'b0;

        if (stop) begin
            // Stop overrides everything, including a simultaneous start.
            state_d   = ST_IDLE;
            wait_d    = '0;
            beat_d    = '0;
            restart_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_FETCH_NOTE;
                    end
                end

                ST_FETCH_NOTE: begin
                    wait_d  = '0;
                    state_d = ST_WAIT_NOTE;
                end

                ST_WAIT_NOTE: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_d = '0;
                        if (value == END_OF_SONG) begin
`ifdef MUSIC_SEQ_LOOP_EN
                            restart_d = 1'b1;
                            state_d   = ST_FETCH_NOTE;
`else
                            state_d   = ST_DONE;
`endif
                        end else begin
                            rest_d = value[REST_BIT];
                            if (!value[REST_BIT]) begin
                                note_d = value[6:0];
                            end
                            state_d = ST_FETCH_DUR;
                        end
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end

                ST_FETCH_DUR: begin
                    wait_d  = '0;
                    state_d = ST_WAIT_DUR;
                end

                ST_WAIT_DUR: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_d  = '0;
                        dur_d   = decode_duration(value);
                        beat_d  = '0;
                        state_d = ST_PLAY;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end

                ST_PLAY: begin
                    if (tick) begin
                        if (last_beat) begin
                            beat_d  = '0;
                            state_d = ST_FETCH_NOTE;
                        end else begin
                            beat_d = beat_q + 9'd1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            rest_q    <= 1'b0;
            note_q    <= '0;
            dur_q     <= '0;
            beat_q    <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rest_q    <= rest_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            beat_q    <= beat_d;
            restart_q <= restart_d;
        end
    end

    assign read    = (state_q == ST_FETCH_NOTE) || (state_q == ST_FETCH_DUR);
    assign restart = restart_q;
    assign note    = note_q;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    // The final tick of a multi-tick note is left silent to articulate repeated notes.
    assign gate    = play_en && !rest_q && !(last_beat && (dur_q >= 9'd2));

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: a latency-accurate decoder model feeds songs,
// and a cycle timeline derived from the song rules is compared against the outputs.
module tb_music_sequencer;

    localparam int TD = 4;
    localparam int DL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] value = 8'h5A;
    logic       read;
    logic       restart;
    logic [6:0] note;
    logic       gate;
    logic       busy;
    logic       done;

    logic [11:0] obs;
    logic [7:0]  dec_stream[$];
    logic [11:0] exp_q[$];
    logic [6:0]  model_note;
    int          checks = 0;
    int          failures = 0;

    music_sequencer #(
        .TICK_DIV(TD),
        .DEC_LAT (DL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .value  (value),
        .read   (read),
        .restart(restart),
        .note   (note),
        .gate   (gate),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    assign obs = {restart, read, gate, busy, done, note};

    // Decoder model: the requested byte is driven only around the sampling edge
    // DL clocks after the read pulse; garbage is driven at all other times.
    initial begin
        int dec_ptr;
        int dec_idx;
        int dec_cnt;
        dec_ptr = 0;
        dec_idx = 0;
        dec_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                dec_ptr = 0;
                dec_cnt = 0;
                value   = 8'($urandom_range(1, 255));
            end else begin
                if (restart) dec_ptr = 0;
                value = 8'($urandom_range(1, 255));
                if (read) begin
                    dec_idx = dec_ptr;
                    dec_ptr++;
                    dec_cnt = 1;
                end else if (dec_cnt > 0) begin
                    dec_cnt++;
                    if (dec_cnt == DL + 1) begin
                        value   = (dec_idx < dec_stream.size()) ? dec_stream[dec_idx] : 8'h00;
                        dec_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, expv, $time);
        end
    endtask

    task automatic push(input logic r, input logic rd, input logic g, input logic b, input logic d);
        exp_q.push_back({r, rd, g, b, d, model_note});
    endtask

    // Expected per-clock outputs from the cycle after start, derived from the song bytes.
    task automatic build();
        int         i;
        int         n;
        logic [7:0] b;
        logic       rs;
        logic       rf;
`ifdef MUSIC_SEQ_LOOP_EN
        logic       wrapped;
        wrapped = 1'b0;
`endif
        exp_q.delete();
        i  = 0;
        rf = 1'b0;
        forever begin
            push(rf, 1'b1, 1'b0, 1'b1, 1'b0);
            rf = 1'b0;
            repeat (DL) push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            b = dec_stream[i];
            i++;
            if (b == 8'h00) begin
`ifdef MUSIC_SEQ_LOOP_EN
                i       = 0;
                rf      = 1'b1;
                wrapped = 1'b1;
                continue;
`else
                push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                break;
`endif
            end
            rs = b[7];
            if (!rs) model_note = b[6:0];
            push(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            repeat (DL) push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            b = dec_stream[i];
            i++;
            n = (b == 8'h00) ? 256 : int'(b);
            for (int k = 0; k < n * TD; k++) begin
                push(1'b0, 1'b0, !rs && !(n >= 2 && k >= (n - 1) * TD), 1'b1, 1'b0);
            end
`ifdef MUSIC_SEQ_LOOP_EN
            if (wrapped) break;
`endif
        end
    endtask

    // Compares the first cnt timeline entries; start is poked at random while busy.
    task automatic run_tl(input string tag, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            chk($sformatf("%s[%0d]", tag, k), obs, exp_q[k]);
            start = exp_q[k][8] && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", obs, 12'h000);
        reset = 1'b1;
        @(negedge clk);
        model_note = 7'd0;
    endtask

    task automatic load_base();
        dec_stream = '{8'd129, 8'd144, 8'd1, 8'd254, 8'd8, 8'd17, 8'd0};
    endtask

    task automatic check_held_done();
`ifndef MUSIC_SEQ_LOOP_EN
        repeat (3) begin
            chk("done_held", obs, {5'b00001, model_note});
            @(negedge clk);
        end
`endif
    endtask

    initial begin
        int         n_stop;
        logic [6:0] held;
        model_note = 7'd0;

        // Song from the reference stream.
        do_reset();
        load_base();
        build();
        pulse_start();
        run_tl("song", exp_q.size());
        check_held_done();
        $display("scenario base_song checks=%0d", checks);

        // Duration byte zero plays for 256 ticks.
        do_reset();
        dec_stream = '{8'd60, 8'd0, 8'd0};
        build();
        pulse_start();
        run_tl("dur256", exp_q.size());
        check_held_done();
        $display("scenario dur256 checks=%0d", checks);

        // Random short songs.
        for (int s = 0; s < 3; s++) begin
            do_reset();
            dec_stream.delete();
            for (int j = 0; j < 4; j++) begin
                dec_stream.push_back(8'($urandom_range(1, 255)));
                dec_stream.push_back(8'($urandom_range(0, 5)));
            end
            dec_stream.push_back(8'h00);
            build();
            pulse_start();
            run_tl($sformatf("rand%0d", s), exp_q.size());
            check_held_done();
            $display("scenario random_song %0d checks=%0d", s, checks);
        end

        // Stop in the middle of the note-1 PLAY, then replay from the top.
        do_reset();
        load_base();
        build();
        n_stop = 2 * (1 + DL) + 144 * TD + 2 * (1 + DL) + 100;
        pulse_start();
        run_tl("pre_stop", n_stop);
        held = exp_q[n_stop][6:0];
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_idle", obs, {5'b10000, held});
        @(negedge clk);
        chk("stop_restart_once", obs, {5'b00000, held});
        model_note = held;
        build();
        pulse_start();
        run_tl("replay", exp_q.size());
        $display("scenario stop_mid_play checks=%0d", checks);

        // Start together with stop from IDLE: stop wins.
        do_reset();
        load_base();
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_same", obs, {5'b10000, model_note});
        repeat (3) begin
            @(negedge clk);
            chk("stay_idle", obs, {5'b00000, model_note});
        end
        $display("scenario start_stop_together checks=%0d", checks);

        // Reset asserted mid WAIT_DUR clears outputs at once; playback restarts from byte 0.
        do_reset();
        load_base();
        build();
        pulse_start();
        run_tl("pre_reset", 2 + DL + 1);
        #2 reset = 1'b0;
        #1 chk("async_reset", obs, 12'h000);
        @(negedge clk);
        chk("reset_hold", obs, 12'h000);
        reset = 1'b1;
        @(negedge clk);
        model_note = 7'd0;
        build();
        pulse_start();
        run_tl("after_reset", exp_q.size());
        check_held_done();
        $display("scenario reset_mid_fetch checks=%0d", checks);

        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
